// File: rtl/z80_dma_master.sv
// Z80 memory-to-memory DMA master: CPU register window, bus request handshake
// and a read/write strobe sequencer that copies LEN bytes from SRC to DST.
module z80_dma_master #(
    parameter int unsigned STB_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_ena,
    input  logic        memrd,
    input  logic        memwr,
    input  logic [3:0]  cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic        bus_oe,
    output logic [15:0] bus_addr,
    output logic        bus_mreq_n,
    output logic        bus_rd_n,
    output logic        bus_wr_n,
    input  logic [7:0]  bus_din,
    output logic [7:0]  bus_dout,
    output logic        done_pulse
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD_ADR,
        S_RD_STB,
        S_WR_ADR,
        S_WR_STB,
        S_REL
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;
    logic                busrq_n_q, busrq_n_d;
    logic                bus_oe_q, bus_oe_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic                bus_mreq_n_q, bus_mreq_n_d;
    logic                bus_rd_n_q, bus_rd_n_d;
    logic                bus_wr_n_q, bus_wr_n_d;
    logic [DATA_W-1:0]   bus_dout_q, bus_dout_d;
    logic                done_pulse_q, done_pulse_d;

    logic reg_wr;
    logic ctrl_wr;
    logic start_req;
    logic abort_req;
    logic abort_pend;
    logic status_rd;
    logic go_start;
    logic zero_start;

    // CPU-side decode; counters and start are locked out while a transfer owns them
    assign reg_wr     = dma_ena && memwr && !busy_q;
    assign ctrl_wr    = dma_ena && memwr && (cpu_addr == 4'h8);
    assign start_req  = ctrl_wr && cpu_din[0] && (state_q == S_IDLE);
    assign abort_req  = ctrl_wr && cpu_din[1] && busy_q;
    assign abort_pend = abort_q || abort_req;
    assign status_rd  = dma_ena && memrd && (cpu_addr == 4'h9);

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        abort_d      = abort_q;
        bus_addr_d   = bus_addr_q;
        bus_dout_d   = bus_dout_q;
        go_start     = 1'b0;
        zero_start   = 1'b0;

        if (reg_wr) begin
            case (cpu_addr)
                4'h0:    src_d[7:0]  = cpu_din;
                4'h1:    src_d[15:8] = cpu_din;
                4'h2:    dst_d[7:0]  = cpu_din;
                4'h3:    dst_d[15:8] = cpu_din;
                4'h4:    len_d[7:0]  = cpu_din;
                4'h5:    len_d[15:8] = cpu_din;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    if (len_q != '0) begin
                        go_start = 1'b1;
                        state_d  = S_REQ;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (abort_pend) begin
                    state_d = S_REL;
                end else if (!busak_n) begin
                    state_d = S_RD_ADR;
                end
            end
            S_RD_ADR: begin
                cnt_d   = '0;
                state_d = S_RD_STB;
            end
            S_RD_STB: begin
                if (cnt_q == STB_LAST) begin
                    data_d  = bus_din;
                    state_d = S_WR_ADR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR_ADR: begin
                cnt_d   = '0;
                state_d = S_WR_STB;
            end
            S_WR_STB: begin
                if (cnt_q == STB_LAST) begin
                    src_d = src_q + ADDR_W'(1);
                    dst_d = dst_q + ADDR_W'(1);
                    len_d = len_q - ADDR_W'(1);
                    if ((len_q == ADDR_W'(1)) || abort_pend) begin
                        state_d = S_REL;
                    end else begin
                        state_d = S_RD_ADR;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d == S_IDLE) || (state_d == S_REL)) begin
            abort_d = 1'b0;
        end else if (abort_req) begin
            abort_d = 1'b1;
        end

        // done set (REL entry, REL cycle, zero-length start) overrides any clear
        if (go_start || status_rd) begin
            done_d = 1'b0;
        end
        if (zero_start || (state_d == S_REL) || (state_q == S_REL)) begin
            done_d = 1'b1;
        end

        // Bus outputs are registered from the next state so they line up with state_q
        busy_d       = state_d inside {S_REQ, S_RD_ADR, S_RD_STB, S_WR_ADR, S_WR_STB};
        busrq_n_d    = !busy_d;
        bus_oe_d     = state_d inside {S_RD_ADR, S_RD_STB, S_WR_ADR, S_WR_STB};
        bus_mreq_n_d = !(state_d inside {S_RD_STB, S_WR_STB});
        bus_rd_n_d   = (state_d != S_RD_STB);
        bus_wr_n_d   = (state_d != S_WR_STB);
        done_pulse_d = zero_start || (state_d == S_REL);
        if (state_d == S_RD_ADR) begin
            bus_addr_d = src_d;
        end
        if (state_d == S_WR_ADR) begin
            bus_addr_d = dst_d;
            bus_dout_d = data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
            busrq_n_q    <= 1'b1;
            bus_oe_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_mreq_n_q <= 1'b1;
            bus_rd_n_q   <= 1'b1;
            bus_wr_n_q   <= 1'b1;
            bus_dout_q   <= '0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
            busrq_n_q    <= busrq_n_d;
            bus_oe_q     <= bus_oe_d;
            bus_addr_q   <= bus_addr_d;
            bus_mreq_n_q <= bus_mreq_n_d;
            bus_rd_n_q   <= bus_rd_n_d;
            bus_wr_n_q   <= bus_wr_n_d;
            bus_dout_q   <= bus_dout_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    // Register readback shows the live counters
    always_comb begin
        cpu_dout = 8'hFF;
        case (cpu_addr)
            4'h0:    cpu_dout = src_q[7:0];
            4'h1:    cpu_dout = src_q[15:8];
            4'h2:    cpu_dout = dst_q[7:0];
            4'h3:    cpu_dout = dst_q[15:8];
            4'h4:    cpu_dout = len_q[7:0];
            4'h5:    cpu_dout = len_q[15:8];
            4'h8:    cpu_dout = 8'h00;
            4'h9:    cpu_dout = {6'b0, done_q, busy_q};
            default: cpu_dout = 8'hFF;
        endcase
    end

    assign busrq_n    = busrq_n_q;
    assign bus_oe     = bus_oe_q;
    assign bus_addr   = bus_addr_q;
    assign bus_mreq_n = bus_mreq_n_q;
    assign bus_rd_n   = bus_rd_n_q;
    assign bus_wr_n   = bus_wr_n_q;
    assign bus_dout   = bus_dout_q;
    assign done_pulse = done_pulse_q;

endmodule

// File: doc/z80_dma_master.md
Name: z80_dma_master

Overview:
- Memory-to-memory DMA engine and Z80 bus initiator. Its CPU-side register window is selected by dma_ena (0x7800-0x780F).
- When started, it requests the bus with busrq_n and waits for busak_n.
- While it holds the bus it drives addr, mreq_n, rd_n and wr_n itself. The shared address decoder consumes these signals to select ROM, RAM, object, tile, I/O or port targets.
- When the transfer finishes it releases the bus and raises a one-cycle completion pulse.

Parameters:
- STB_CYCLES, default 2: cycles that mreq_n plus rd_n, or mreq_n plus wr_n, are held low per access. Legal range is 1 to 15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- dma_ena  in  1  decoded select for the register window
- memrd  in  1  decoded CPU memory read
- memwr  in  1  decoded CPU memory write
- cpu_addr  in  4  CPU address bits [3:0]
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  register read data
- busrq_n  out  1  Z80 bus request, active low
- busak_n  in  1  Z80 bus acknowledge, active low
- bus_oe  out  1  high while the DMA drives the bus; gates the tri-state buffers and decoder muxing
- bus_addr  out  16  DMA address
- bus_mreq_n  out  1  DMA memory request
- bus_rd_n  out  1  DMA read strobe
- bus_wr_n  out  1  DMA write strobe
- bus_din  in  8  read data from the target
- bus_dout  out  8  write data to the target
- done_pulse  out  1  one-cycle completion strobe

Behaviour:
- Registers (cpu_addr):
  - 0x0 SRC_LO, 0x1 SRC_HI, 0x2 DST_LO, 0x3 DST_HI, 0x4 LEN_LO, 0x5 LEN_HI.
  - 0x8 CTRL, write-only: bit0 = start, bit1 = abort.
  - 0x9 STATUS: bit0 = busy, bit1 = done.
  - All other offsets read 0xFF.
- Register writes occur when dma_ena and memwr are high on a clock edge.
- cpu_dout is a combinational mux on cpu_addr.
  - SRC, DST and LEN read back their live counters.
  - CTRL reads 0x00.
- A STATUS read (dma_ena and memrd high) clears done on that edge.
- Reset values:
  - All registers = 0.
  - busy = 0, done = 0.
  - busrq_n = 1, bus_oe = 0.
  - bus_mreq_n = bus_rd_n = bus_wr_n = 1.
  - bus_addr = 0, bus_dout = 0, done_pulse = 0.
- While busy, writes to SRC, DST, LEN and CTRL.start are ignored. CTRL.abort is accepted.
- FSM:
  - IDLE
    - Start with LEN != 0: go to REQ, set busy = 1, clear done, set busrq_n = 0 in the next cycle.
    - Start with LEN == 0: stay in IDLE, set done = 1, pulse done_pulse once, never request the bus.
  - REQ: hold busrq_n = 0 until a sampled busak_n == 0, then go to RD_ADR.
  - RD_ADR: 1 cycle; bus_oe = 1, bus_addr = SRC, all strobes high.
  - RD_STB: STB_CYCLES cycles with bus_mreq_n = 0 and bus_rd_n = 0. The data register latches bus_din on the last cycle.
  - WR_ADR: 1 cycle; bus_addr = DST, bus_dout = data register, strobes high.
  - WR_STB: STB_CYCLES cycles with bus_mreq_n = 0 and bus_wr_n = 0. bus_addr and bus_dout are held stable.
  - On the exit edge of WR_STB:
    - SRC += 1 and DST += 1, each 16-bit wrapping, so 0xFFFF becomes 0x0000.
    - LEN -= 1.
    - If the new LEN == 0 or abort is pending, go to REL; otherwise go to RD_ADR.
  - REL: 1 cycle.
    - bus_oe = 0, strobes high, busrq_n = 1.
    - busy = 0, done = 1, done_pulse = 1.
    - Then return to IDLE.
- Throughput: 2 + 2×STB_CYCLES cycles per byte once busak_n is low.
- Abort:
  - While in REQ: go straight to REL. No bus cycles are issued, and done is still set.
  - During a byte: the current read/write pair completes, then the FSM goes to REL. The counters reflect the bytes actually moved.
- busak_n is sampled only in REQ. Later changes are ignored; the Z80 does not revoke an acknowledge.
- Strobes are never low in an *_ADR or REL cycle. rd_n and wr_n are never both low.
- A simultaneous STATUS read and REL cycle leaves done = 1; the set wins over the clear.
- rst mid-transfer:
  - Next edge: all outputs at reset values, FSM in IDLE, no done_pulse.
  - The bus is released within 1 cycle.

Test Plan:
- Basic copy:
  - Stimulus: SRC = 0x6000, DST = 0x7000, LEN = 3, start. busak_n goes low 4 cycles after busrq_n.
  - Required: three reads at 0x6000-0x6002 and three writes at 0x7000-0x7002 carrying the read data; 6 cycles per byte with STB_CYCLES = 2.
  - Then done_pulse once; STATUS = 0x02, and a second read returns 0x00.
- Zero length:
  - Stimulus: LEN = 0, start.
  - Required: busrq_n stays 1, done_pulse on the next cycle, STATUS = 0x02.
- Wrap:
  - Stimulus: SRC = 0xFFFF, DST = 0x6BFF, LEN = 2.
  - Required: read addresses 0xFFFF then 0x0000; write addresses 0x6BFF then 0x6C00; final SRC readback = 0x0001.
- Abort:
  - Stimulus: LEN = 0x0100, abort during the RD_STB of byte 2.
  - Required: byte 2 write completes, REL follows, LEN reads 0x00FE, done = 1.
- Busy lockout and delayed acknowledge:
  - Stimulus: write SRC = 0x1234 while busy; keep busak_n high for 20 cycles.
  - Required: SRC unchanged; bus_oe stays 0 and strobes stay high until busak_n goes low.
- Reset mid-transfer:
  - Stimulus: assert rst in WR_STB.
  - Required: next cycle busrq_n = 1, bus_oe = 0, all strobes high, STATUS = 0x00, no done_pulse.
